cmos_capture_frontend: RTL and testbench

CMOS_CAPTURE_FRONTEND -- requirements
Module: cmos_capture_frontend

---
 rtl/cmos_capture_frontend.sv | 169 ++++++++++++++++
 tb/tb_cmos_capture_frontend.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cmos_capture_frontend.sv
// CMOS camera capture front end: RGB565 byte pairing, 2x2 decimation,
// frame sequencing with post-reset settle skip and geometry checking.
module cmos_capture_frontend #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 2
) (
    input  logic        pixel_clk_cmos_i,
    input  logic        reset_i,
    input  logic        vsync_cmos_i,
    input  logic        href_cmos_i,
    input  logic [7:0]  pixel_data_cmos_i,
    input  logic        enable_i,
    output logic        pixel_valid_o,
    output logic [15:0] pixel_data_o,
    output logic [16:0] write_address_o,
    output logic        frame_start_o,
    output logic        frame_done_o,
    output logic [7:0]  frame_count_o,
    output logic        line_error_o
);

    localparam logic [15:0] LINE_BYTES = 16'(2 * H_ACTIVE);
    localparam logic [15:0] H_PIX      = 16'(H_ACTIVE);
    localparam logic [15:0] V_LINES    = 16'(V_ACTIVE);
    localparam logic [16:0] ADDR_LAST  = 17'((H_ACTIVE / 2) * (V_ACTIVE / 2) - 1);
    localparam logic [7:0]  SKIP_INIT  = 8'(SKIP_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        VBLANK,
        SKIP,
        CAPTURE
    } state_t;

    state_t      state, state_nxt;
    logic        vsync_q, href_q;
    logic [7:0]  skip_cnt;
    logic [15:0] line_idx, pix_idx, byte_cnt;
    logic        phase;
    logic [7:0]  hi_byte;
    logic [16:0] addr_cnt;
    logic        frame_begin, frame_end, skip_dec;

    wire vsync_rise = vsync_cmos_i & ~vsync_q;
    wire vsync_fall = ~vsync_cmos_i & vsync_q;
    wire href_rise  = href_cmos_i & ~href_q;
    wire href_fall  = ~href_cmos_i & href_q;
    // A vsync rise ends the frame even with href still high.
    wire capturing  = (state == CAPTURE) & ~vsync_rise;

    wire emit = ~line_idx[0] & ~pix_idx[0] & (pix_idx < H_PIX) &
                (line_idx < V_LINES) & (addr_cnt <= ADDR_LAST);

    always_ff @(posedge pixel_clk_cmos_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        frame_begin = 1'b0;
        frame_end   = 1'b0;
        skip_dec    = 1'b0;
        unique case (state)
            IDLE: begin
                if (vsync_rise) state_nxt = VBLANK;
            end
            VBLANK: begin
                if (vsync_fall) begin
                    if (skip_cnt != 8'd0) begin
                        state_nxt = SKIP;
                        skip_dec  = 1'b1;
                    end else if (enable_i) begin
                        state_nxt   = CAPTURE;
                        frame_begin = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            SKIP: begin
                if (vsync_rise) state_nxt = VBLANK;
            end
            CAPTURE: begin
                if (vsync_rise) begin
                    state_nxt = VBLANK;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_cmos_i or posedge reset_i) begin
        if (reset_i) begin
            // vsync_q starts high so a level already high at release is not an edge
            vsync_q         <= 1'b1;
            href_q          <= 1'b0;
            skip_cnt        <= SKIP_INIT;
            line_idx        <= '0;
            pix_idx         <= '0;
            byte_cnt        <= '0;
            phase           <= 1'b0;
            hi_byte         <= '0;
            addr_cnt        <= '0;
            pixel_valid_o   <= 1'b0;
            pixel_data_o    <= '0;
            write_address_o <= '0;
            frame_start_o   <= 1'b0;
            frame_done_o    <= 1'b0;
            frame_count_o   <= '0;
            line_error_o    <= 1'b0;
        end else begin
            vsync_q       <= vsync_cmos_i;
            href_q        <= href_cmos_i;
            pixel_valid_o <= 1'b0;
            frame_start_o <= frame_begin;
            frame_done_o  <= frame_end;
            if (skip_dec) skip_cnt <= skip_cnt - 8'd1;
            if (frame_begin) begin
                line_idx        <= '0;
                pix_idx         <= '0;
                byte_cnt        <= '0;
                phase           <= 1'b0;
                addr_cnt        <= '0;
                write_address_o <= '0;
                line_error_o    <= 1'b0;
            end
            if (frame_end) begin
                frame_count_o <= frame_count_o + 8'd1;
                if (line_idx != V_LINES) line_error_o <= 1'b1;
            end
            if (capturing) begin
                if (href_cmos_i) begin
                    if (href_rise) begin
                        hi_byte  <= pixel_data_cmos_i;
                        phase    <= 1'b1;
                        byte_cnt <= 16'd1;
                        pix_idx  <= '0;
                    end else begin
                        if (byte_cnt != 16'hffff) byte_cnt <= byte_cnt + 16'd1;
                        if (!phase) begin
                            hi_byte <= pixel_data_cmos_i;
                            phase   <= 1'b1;
                        end else begin
                            phase   <= 1'b0;
                            pix_idx <= pix_idx + 16'd1;
                            if (emit) begin
                                pixel_valid_o   <= 1'b1;
                                pixel_data_o    <= {hi_byte, pixel_data_cmos_i};
                                write_address_o <= addr_cnt;
                                addr_cnt        <= addr_cnt + 17'd1;
                            end
                        end
                    end
                end else if (href_fall) begin
                    if (byte_cnt != LINE_BYTES) line_error_o <= 1'b1;
                    line_idx <= line_idx + 16'd1;
                    phase    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmos_capture_frontend.sv
// Scoreboard bench for cmos_capture_frontend on a reduced 8x6 geometry.
module tb_cmos_capture_frontend;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int SK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        en = 1'b1;
    logic [7:0]  din = '0;
    logic        pixel_valid_o;
    logic [15:0] pixel_data_o;
    logic [16:0] write_address_o;
    logic        frame_start_o;
    logic        frame_done_o;
    logic [7:0]  frame_count_o;
    logic        line_error_o;

    always #5 clk = ~clk;

    cmos_capture_frontend #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .SKIP_FRAMES(SK)
    ) dut (
        .pixel_clk_cmos_i (clk),
        .reset_i          (rst),
        .vsync_cmos_i     (vsync),
        .href_cmos_i      (href),
        .pixel_data_cmos_i(din),
        .enable_i         (en),
        .pixel_valid_o    (pixel_valid_o),
        .pixel_data_o     (pixel_data_o),
        .write_address_o  (write_address_o),
        .frame_start_o    (frame_start_o),
        .frame_done_o     (frame_done_o),
        .frame_count_o    (frame_count_o),
        .line_error_o     (line_error_o)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [16:0] a;
        logic [31:0] c;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   n_start = 0;
    int   n_done = 0;

    int   m_skip = SK;
    int   m_fc = 0;
    int   m_starts = 0;
    int   m_done = 0;
    int   m_addr = 0;
    int   m_nl = 0;
    bit   m_cap = 1'b0;
    bit   m_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_start_o) n_start++;
        if (frame_done_o) n_done++;
        if (pixel_valid_o) begin
            chk("px_pend", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                chk("px_data", 32'(pixel_data_o), 32'(mon_e.d));
                chk("px_addr", 32'(write_address_o), 32'(mon_e.a));
                chk("px_lat", 32'(cyc), mon_e.c);
            end
        end
    end

    task automatic check_reset_outs();
        chk("rst_pv", 32'(pixel_valid_o), 0);
        chk("rst_le", 32'(line_error_o), 0);
        chk("rst_fs", 32'(frame_start_o), 0);
        chk("rst_fd", 32'(frame_done_o), 0);
        chk("rst_fc", 32'(frame_count_o), 0);
        chk("rst_pd", 32'(pixel_data_o), 0);
        chk("rst_wa", 32'(write_address_o), 0);
    endtask

    task automatic run_frame(input int nl, input int short_ln,
                             input int rst_ln, input int drop_ln,
                             input logic [7:0] seed, input logic [7:0] step);
        logic [7:0] cur;
        logic [7:0] hi;
        int nb;
        hi = '0;
        vsync = 1'b1;
        if (m_cap) begin
            m_fc = (m_fc + 1) % 256;
            m_done++;
            if (m_nl != V) m_err = 1'b1;
        end
        m_cap = 1'b0;
        repeat (4) @(negedge clk);
        chk("fcount", 32'(frame_count_o), 32'(m_fc));
        chk("done_n", 32'(n_done), 32'(m_done));
        chk("lerr_end", 32'(line_error_o), 32'(m_err));
        vsync = 1'b0;
        if (m_skip > 0) begin
            m_skip--;
        end else if (en) begin
            m_cap = 1'b1;
            m_starts++;
            m_addr = 0;
            m_err = 1'b0;
        end
        m_nl = nl;
        repeat (3) @(negedge clk);
        chk("start_n", 32'(n_start), 32'(m_starts));
        chk("lerr_st", 32'(line_error_o), 32'(m_err));
        cur = seed;
        for (int l = 0; l < nl; l++) begin
            if (l == drop_ln) en = 1'b0;
            nb = (l == short_ln) ? 2 * H - 2 : 2 * H;
            href = 1'b1;
            for (int k = 0; k < nb; k++) begin
                if (l == rst_ln && k == 5) rst = 1'b0;
                din = cur;
                if (k % 2 == 0) begin
                    hi = cur;
                end else if (m_cap && l % 2 == 0 && (k / 2) % 2 == 0 &&
                             k / 2 < H && l < V) begin
                    q.push_back('{{hi, cur}, 17'(m_addr), 32'(cyc + 1)});
                    m_addr++;
                end
                cur = cur + step;
                @(negedge clk);
                if (l == rst_ln && k == 1) begin
                    chk("pv_pre", 32'(pixel_valid_o), 1);
                    #1 rst = 1'b1;
                    #1;
                    check_reset_outs();
                    q.delete();
                    m_cap = 1'b0;
                    m_skip = SK;
                    m_fc = 0;
                    m_err = 1'b0;
                end
            end
            href = 1'b0;
            if (m_cap && l == short_ln) m_err = 1'b1;
            repeat (3) @(negedge clk);
            if (l == short_ln) chk("lerr_ln", 32'(line_error_o), 32'(m_err));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outs();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_frame(V, -1, -1, -1, 8'h00, 8'h01);
        run_frame(V, -1, -1, -1, 8'h40, 8'h05);
        run_frame(V, -1, -1, -1, 8'hf8, 8'h27);
        run_frame(V, 1, -1, -1, 8'h00, 8'h01);
        run_frame(V, -1, -1, 2, 8'h10, 8'h03);
        run_frame(V, -1, -1, -1, 8'h22, 8'h07);
        en = 1'b1;
        run_frame(V - 1, -1, -1, -1, 8'h33, 8'h0b);
        run_frame(V, -1, 2, -1, 8'h55, 8'h11);
        run_frame(V, -1, -1, -1, 8'h66, 8'h01);
        run_frame(V, -1, -1, -1, 8'h77, 8'h02);
        run_frame(V, -1, -1, -1, 8'h88, 8'h0d);
        run_frame(0, -1, -1, -1, 8'h00, 8'h01);
        repeat (5) @(negedge clk);
        chk("q_left", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
